move_controller: RTL and testbench
==================================

MOVE_CONTROLLER -- requirements
Module: move_controller

Interface
REQ-001 Parameter NCELLS, default 9: number of playable board cells, indices 0..NCELLS-1.
REQ-002 Parameter POS_W, default 4: width of the position code.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 play  input  1  player move request, level from debounced button; acted on at its rising edge.
REQ-006 pc  input  1  computer move request, level from debounced button; acted on at its rising edge.
REQ-007 player_pos  input  POS_W  player-selected cell index from switches.
REQ-008 occupied  input  NCELLS  bit i high means cell i already holds a mark.
REQ-009 game_over  input  1  high when the winner detector reports a win or a draw.
REQ-010 pos_out  output  POS_W  cell index presented to the position decoders.
REQ-011 player_en  output  1  one-cycle enable to the player position decoder.
REQ-012 computer_en  output  1  one-cycle enable to the computer position decoder.
REQ-013 illegal_move  output  1  sticky flag for a rejected player move.
REQ-014 turn  output  1  0 = player to move, 1 = computer to move.

Function
REQ-015 The block SHALL register all outputs; no output is a combinational function of the inputs.
REQ-016 The block SHALL detect a rising edge on play or pc as input high in cycle N and low in cycle N-1.
REQ-017 The FSM SHALL have four states: S_PLAYER, S_CPU_WAIT, S_SCAN and S_DONE.
REQ-018 In S_PLAYER, a play edge with player_pos < NCELLS and occupied[player_pos]=0 SHALL cause the following in cycle N+1: pos_out=player_pos, player_en=1, illegal_move=0, and state S_CPU_WAIT.
REQ-019 In S_PLAYER, a play edge with player_pos >= NCELLS or an occupied target SHALL set illegal_move=1 in cycle N+1, leave state unchanged and keep player_en=0.
REQ-020 In S_CPU_WAIT, a pc edge SHALL clear scan index idx to 0 and enter S_SCAN.
REQ-021 In S_SCAN, each cycle SHALL test occupied[idx]:
- If the cell is free, the next cycle SHALL have pos_out=idx, computer_en=1 and state S_PLAYER.
- If the cell is occupied and idx < NCELLS-1, idx SHALL increment.
- If the cell is occupied and idx = NCELLS-1, the state SHALL become S_DONE.
REQ-022 For a pc edge in cycle N with first free cell k, computer_en SHALL be high in cycle N+2+k.
REQ-023 player_en and computer_en SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per accepted move.
REQ-024 pos_out SHALL hold its last value when neither enable is high.
REQ-025 Play edges outside S_PLAYER and pc edges outside S_CPU_WAIT SHALL be ignored.
REQ-026 game_over=1 in any state SHALL force S_DONE in the next cycle and suppress both enables in that cycle, including when it coincides with a play or pc edge.
REQ-027 S_DONE SHALL be left only by reset.
REQ-028 turn SHALL be 1 in S_CPU_WAIT and S_SCAN, and 0 otherwise.

Reset
REQ-029 Reset SHALL force state=S_PLAYER, idx=0, pos_out=0, player_en=0, computer_en=0, illegal_move=0 and turn=0 in the next cycle.
REQ-030 Reset SHALL clear the stored previous values of play and pc to 0.
REQ-031 Reset asserted in mid-scan or in S_DONE SHALL abort the operation with no enable pulse.

Structure
REQ-032 Shared package tictactoe_pkg SHALL hold NCELLS, POS_W and the FSM state type.
REQ-033 Edge detection SHALL be a sub-module rise_detect (inputs clock, reset, level; output pulse), instantiated once for play and once for pc.

Verification
REQ-034 Legal player move: occupied=0, player_pos=4, play edge in cycle N -> player_en=1 and pos_out=4 in cycle N+1, then turn=1.
REQ-035 Illegal player move: player_pos=11, play edge -> illegal_move=1, no player_en, turn=0. A following legal player_pos=2 -> illegal_move=0 and player_en=1.
REQ-036 Computer scan: occupied=9'b000000111, pc edge in cycle N -> computer_en=1 and pos_out=3 in cycle N+5, turn=0.
REQ-037 Full board during scan: occupied=9'h1FF, pc edge -> no computer_en and state S_DONE. Subsequent play and pc edges -> no enables.
REQ-038 game_over coincident with a play edge -> no player_en and state S_DONE. Reset -> all outputs 0 and state S_PLAYER.
REQ-039 Reset in mid-scan: reset asserted at scan idx=2 -> computer_en stays 0, pos_out=0, and a new play edge is accepted.

Source files
------------

// File: rtl/move_controller_pkg.sv
// Shared board geometry and FSM state encoding for the move controller.
package tictactoe_pkg;

  localparam int NCELLS = 9;
  localparam int POS_W  = 4;

  typedef logic [1:0] state_t;

  localparam logic [1:0] S_PLAYER   = 2'd0;
  localparam logic [1:0] S_CPU_WAIT = 2'd1;
  localparam logic [1:0] S_SCAN     = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

endpackage

// File: rtl/move_controller_if.sv
// Request/board-status inputs and decoder-facing outputs of the move controller.
interface move_controller_if #(
  parameter int NCELLS = 9,
  parameter int POS_W  = 4
) ();

  logic              play;
  logic              pc;
  logic [POS_W-1:0]  player_pos;
  logic [NCELLS-1:0] occupied;
  logic              game_over;
  logic [POS_W-1:0]  pos_out;
  logic              player_en;
  logic              computer_en;
  logic              illegal_move;
  logic              turn;

  // Board side: drives requests and status, observes the decoder outputs.
  modport master (
    output play, pc, player_pos, occupied, game_over,
    input  pos_out, player_en, computer_en, illegal_move, turn
  );

  // Controller side.
  modport slave (
    input  play, pc, player_pos, occupied, game_over,
    output pos_out, player_en, computer_en, illegal_move, turn
  );

endinterface

// File: rtl/move_controller_rise_detect.sv
// Rising-edge detector: pulse is high in the first cycle the level is seen high.
module rise_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic prev;

  // Remember last cycle's level; reset forgets it so a held button re-arms.
  always_ff @(posedge clock) begin
    if (reset) prev <= 1'b0;
    else       prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/move_controller.sv
// Move sequencing for the tic-tac-toe board: accepts player moves, scans for
// the first free cell on a computer request, and pulses the matching decoder.
//
//   state      | meaning
//   -----------+---------------------------------------------------
//   S_PLAYER   | waiting for a player move (play edge)
//   S_CPU_WAIT | player move accepted, waiting for a pc edge
//   S_SCAN     | walking idx upward looking for a free cell
//   S_DONE     | game finished or board full; only reset leaves it
module move_controller #(
  parameter int NCELLS = tictactoe_pkg::NCELLS,
  parameter int POS_W  = tictactoe_pkg::POS_W
) (
  input  logic           clock,
  input  logic           reset,
  move_controller_if.slave bus
);

  import tictactoe_pkg::*;

  localparam int                EXT_N    = 2 ** POS_W;
  localparam logic [POS_W-1:0]  LAST_IDX = POS_W'(NCELLS - 1);

  state_t            state;
  logic [POS_W-1:0]  idx;
  logic [POS_W-1:0]  pos_q;
  logic              player_en_q;
  logic              computer_en_q;
  logic              illegal_q;
  logic              turn_q;
  logic              play_rise;
  logic              pc_rise;
  logic [EXT_N-1:0]  occ_ext;

  rise_detect u_play_rise (
    .clock (clock),
    .reset (reset),
    .level (bus.play),
    .pulse (play_rise)
  );

  rise_detect u_pc_rise (
    .clock (clock),
    .reset (reset),
    .level (bus.pc),
    .pulse (pc_rise)
  );

  // Codes beyond the board read as occupied, so one lookup covers both the
  // range check and the occupancy check.
  assign occ_ext = {{(EXT_N - NCELLS){1'b1}}, bus.occupied};

  // Move sequencing; every output is a register updated here.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= S_PLAYER;
      idx           <= '0;
      pos_q         <= '0;
      player_en_q   <= 1'b0;
      computer_en_q <= 1'b0;
      illegal_q     <= 1'b0;
      turn_q        <= 1'b0;
    end else begin
      player_en_q   <= 1'b0;
      computer_en_q <= 1'b0;
      if (bus.game_over) begin
        state  <= S_DONE;
        turn_q <= 1'b0;
      end else begin
        case (state)
          S_PLAYER: begin
            if (play_rise) begin
              if (!occ_ext[bus.player_pos]) begin
                pos_q       <= bus.player_pos;
                player_en_q <= 1'b1;
                illegal_q   <= 1'b0;
                state       <= S_CPU_WAIT;
                turn_q      <= 1'b1;
              end else begin
                illegal_q   <= 1'b1;
              end
            end
          end
          S_CPU_WAIT: begin
            if (pc_rise) begin
              idx   <= '0;
              state <= S_SCAN;
            end
          end
          S_SCAN: begin
            if (!occ_ext[idx]) begin
              pos_q         <= idx;
              computer_en_q <= 1'b1;
              state         <= S_PLAYER;
              turn_q        <= 1'b0;
            end else if (idx == LAST_IDX) begin
              state  <= S_DONE;
              turn_q <= 1'b0;
            end else begin
              idx <= idx + POS_W'(1);
            end
          end
          S_DONE: begin
            turn_q <= 1'b0;
          end
          default: begin
            state  <= S_PLAYER;
            turn_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pos_out      = pos_q;
  assign bus.player_en    = player_en_q;
  assign bus.computer_en  = computer_en_q;
  assign bus.illegal_move = illegal_q;
  assign bus.turn         = turn_q;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller; inputs change and outputs are sampled
// on the falling edge.
module tb_move_controller;

  import tictactoe_pkg::*;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic seen_en;

  move_controller_if #(.NCELLS(9), .POS_W(4)) bus ();

  move_controller #(.NCELLS(9), .POS_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // The two decoder enables must never fire together.
  always @(negedge clock) begin
    if (!reset && (bus.player_en || bus.computer_en))
      chk("en_exclusive", 32'(bus.player_en & bus.computer_en), 32'd0);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.play = 1'b0;
    bus.pc = 1'b0;
    bus.player_pos = '0;
    bus.occupied = '0;
    bus.game_over = 1'b0;
    step();
    step();
    reset = 1'b0;
    chk("rst_pos", 32'(bus.pos_out), 32'd0);
    chk("rst_pen", 32'(bus.player_en), 32'd0);
    chk("rst_cen", 32'(bus.computer_en), 32'd0);
    chk("rst_ill", 32'(bus.illegal_move), 32'd0);
    chk("rst_turn", 32'(bus.turn), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(S_PLAYER));

    // Legal player move to cell 4.
    bus.player_pos = 4'd4;
    bus.play = 1'b1;
    step();
    chk("legal_pen", 32'(bus.player_en), 32'd1);
    chk("legal_pos", 32'(bus.pos_out), 32'd4);
    chk("legal_turn", 32'(bus.turn), 32'd1);
    chk("legal_ill", 32'(bus.illegal_move), 32'd0);
    bus.play = 1'b0;
    step();
    chk("pen_one_cycle", 32'(bus.player_en), 32'd0);
    chk("pos_hold", 32'(bus.pos_out), 32'd4);

    // Play edge while waiting for the computer is ignored.
    bus.player_pos = 4'd1;
    bus.play = 1'b1;
    step();
    chk("ign_play_pen", 32'(bus.player_en), 32'd0);
    chk("ign_play_pos", 32'(bus.pos_out), 32'd4);
    bus.play = 1'b0;
    step();

    // Computer scan: cells 0..2 taken, first free is 3 -> enable at N+5.
    bus.occupied = 9'b000000111;
    bus.pc = 1'b1;
    step();
    bus.pc = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("scan_cen_n%0d", i), 32'(bus.computer_en), 32'd0);
      chk($sformatf("scan_turn_n%0d", i), 32'(bus.turn), 32'd1);
      step();
    end
    chk("scan_cen", 32'(bus.computer_en), 32'd1);
    chk("scan_pos", 32'(bus.pos_out), 32'd3);
    chk("scan_turn", 32'(bus.turn), 32'd0);
    step();
    chk("cen_one_cycle", 32'(bus.computer_en), 32'd0);

    // Out-of-range player move.
    bus.occupied = '0;
    bus.player_pos = 4'd11;
    bus.play = 1'b1;
    step();
    chk("oor_ill", 32'(bus.illegal_move), 32'd1);
    chk("oor_pen", 32'(bus.player_en), 32'd0);
    chk("oor_turn", 32'(bus.turn), 32'd0);
    bus.play = 1'b0;
    step();
    chk("ill_sticky", 32'(bus.illegal_move), 32'd1);

    // Occupied target is also rejected.
    bus.occupied = 9'b000010000;
    bus.player_pos = 4'd4;
    bus.play = 1'b1;
    step();
    chk("occ_ill", 32'(bus.illegal_move), 32'd1);
    chk("occ_pen", 32'(bus.player_en), 32'd0);
    bus.play = 1'b0;
    step();

    // Legal move to cell 2 clears the flag.
    bus.occupied = '0;
    bus.player_pos = 4'd2;
    bus.play = 1'b1;
    step();
    chk("relegal_ill", 32'(bus.illegal_move), 32'd0);
    chk("relegal_pen", 32'(bus.player_en), 32'd1);
    chk("relegal_pos", 32'(bus.pos_out), 32'd2);
    bus.play = 1'b0;
    step();

    // Full board during scan ends the game.
    bus.occupied = 9'h1FF;
    bus.pc = 1'b1;
    step();
    bus.pc = 1'b0;
    seen_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen_en = seen_en | bus.computer_en;
      step();
    end
    chk("full_cen", 32'(seen_en), 32'd0);
    chk("full_state", 32'(dut.state), 32'(S_DONE));
    chk("full_turn", 32'(bus.turn), 32'd0);
    bus.occupied = '0;
    bus.player_pos = 4'd0;
    seen_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.play = 1'b1;
      bus.pc = 1'b1;
      step();
      seen_en = seen_en | bus.player_en | bus.computer_en;
      bus.play = 1'b0;
      bus.pc = 1'b0;
      step();
      seen_en = seen_en | bus.player_en | bus.computer_en;
    end
    chk("done_no_en", 32'(seen_en), 32'd0);
    chk("done_stays", 32'(dut.state), 32'(S_DONE));

    // Reset returns to the idle player state.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_pos", 32'(bus.pos_out), 32'd0);
    chk("rst2_state", 32'(dut.state), 32'(S_PLAYER));

    // game_over on the same cycle as a legal play edge wins.
    bus.player_pos = 4'd5;
    bus.play = 1'b1;
    bus.game_over = 1'b1;
    step();
    chk("go_pen", 32'(bus.player_en), 32'd0);
    chk("go_state", 32'(dut.state), 32'(S_DONE));
    bus.play = 1'b0;
    bus.game_over = 1'b0;
    step();
    chk("go_pen2", 32'(bus.player_en), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("go_rst_pos", 32'(bus.pos_out), 32'd0);
    chk("go_rst_ill", 32'(bus.illegal_move), 32'd0);
    chk("go_rst_turn", 32'(bus.turn), 32'd0);
    chk("go_rst_state", 32'(dut.state), 32'(S_PLAYER));

    // Reset in the middle of a scan aborts it.
    bus.player_pos = 4'd6;
    bus.play = 1'b1;
    step();
    chk("ms_pen", 32'(bus.player_en), 32'd1);
    chk("ms_pos", 32'(bus.pos_out), 32'd6);
    bus.play = 1'b0;
    bus.occupied = 9'b000011111;
    bus.pc = 1'b1;
    step();
    bus.pc = 1'b0;
    step();
    step();
    chk("ms_idx", 32'(dut.idx), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.occupied = '0;
    seen_en = bus.computer_en;
    for (int i = 0; i < 5; i++) begin
      step();
      seen_en = seen_en | bus.computer_en;
    end
    chk("ms_cen", 32'(seen_en), 32'd0);
    chk("ms_pos0", 32'(bus.pos_out), 32'd0);
    chk("ms_state", 32'(dut.state), 32'(S_PLAYER));
    bus.player_pos = 4'd7;
    bus.play = 1'b1;
    step();
    chk("ms_new_pen", 32'(bus.player_en), 32'd1);
    chk("ms_new_pos", 32'(bus.pos_out), 32'd7);
    bus.play = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
